// File: rtl/simon_pipeline_ctrl.sv
// Flow control and key sequencing for the Simon 32/64 pipeline: valid tagging, credit-limited
// acceptance, FWFT result FIFO. Define SIMON_CTRL_STATS_EN to add blk_count/stall_count outputs.
module simon_pipeline_ctrl #(
    parameter int PIPE_LAT  = 33,
    parameter int KEY_LAT   = 32,
    parameter int OUT_DEPTH = 36
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [31:0]                      s_data,
    input  logic                             key_valid,
    output logic                             key_ready,
    input  logic [63:0]                      key_data,
    output logic [31:0]                      pipe_plaintext,
    output logic [63:0]                      pipe_keytext,
    input  logic [31:0]                      pipe_ciphertext,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [31:0]                      m_data,
    output logic                             busy,
    output logic [$clog2(OUT_DEPTH+1)-1:0]   in_flight
`ifdef SIMON_CTRL_STATS_EN
    ,
    output logic [31:0]                      blk_count,
    output logic [31:0]                      stall_count
`endif
);

    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int KW = $clog2(KEY_LAT + 1);
    localparam logic [KW-1:0] KEY_LOAD  = KW'(KEY_LAT - 1);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(OUT_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {NOKEY, RUN, DRAIN, LOAD} state_t;

    state_t              r_state;
    logic [63:0]         r_keytext;
    logic [63:0]         r_pending;
    logic [KW-1:0]       r_key_cnt;
    logic [PIPE_LAT-1:0] r_vsr;
    logic [CW-1:0]       r_in_flight;
    logic [CW-1:0]       r_mem_cnt;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [31:0]         r_mem [OUT_DEPTH];
    logic                r_m_valid;
    logic [31:0]         r_m_data;

    logic                w_accept;
    logic                w_key_acc;
    logic                w_push;
    logic                w_pop;
    logic                w_head_free;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic                w_bypass;
    logic [CW-1:0]       w_fifo_count;
    logic [CW:0]         w_credit_used;

    assign pipe_plaintext = s_data;
    assign pipe_keytext   = r_keytext;
    assign m_valid        = r_m_valid;
    assign m_data         = r_m_data;
    assign in_flight      = r_in_flight;

    assign w_fifo_count  = r_mem_cnt + CW'(r_m_valid);
    assign w_credit_used = {1'b0, r_in_flight} + {1'b0, w_fifo_count};
    assign s_ready       = (r_state == RUN) && (w_credit_used < DEPTH_C);
    assign key_ready     = (r_state == NOKEY) || (r_state == RUN);
    assign busy          = (r_state != RUN) || (r_in_flight != '0);

    assign w_accept  = s_valid && s_ready;
    assign w_key_acc = key_valid && key_ready;
    assign w_push    = r_vsr[PIPE_LAT-1];
    assign w_pop     = r_m_valid && m_ready;

    // The head register refills from the RAM first; an empty RAM lets a push bypass straight into it.
    assign w_head_free = !r_m_valid || m_ready;
    assign w_mem_rd    = w_head_free && (r_mem_cnt != '0);
    assign w_bypass    = w_head_free && (r_mem_cnt == '0) && w_push;
    assign w_mem_wr    = w_push && !w_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= NOKEY;
            r_keytext <= '0;
            r_key_cnt <= '0;
        end else begin
            case (r_state)
                NOKEY: if (w_key_acc) begin
                    r_keytext <= key_data;
                    r_key_cnt <= KEY_LOAD;
                    r_state   <= LOAD;
                end
                RUN: if (w_key_acc) begin
                    r_pending <= key_data;
                    r_state   <= DRAIN;
                end
                DRAIN: if (r_in_flight == '0) begin
                    r_keytext <= r_pending;
                    r_key_cnt <= KEY_LOAD;
                    r_state   <= LOAD;
                end
                LOAD: begin
                    r_key_cnt <= r_key_cnt - KW'(1);
                    if (r_key_cnt == '0) r_state <= RUN;
                end
                default: r_state <= NOKEY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsr       <= '0;
            r_in_flight <= '0;
        end else begin
            r_vsr <= {r_vsr[PIPE_LAT-2:0], w_accept};
            if (w_accept && !w_push)      r_in_flight <= r_in_flight + CW'(1);
            else if (!w_accept && w_push) r_in_flight <= r_in_flight - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_mem_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            if (w_mem_rd || w_bypass) r_m_valid <= 1'b1;
            else if (w_pop)           r_m_valid <= 1'b0;
            if (w_mem_rd) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            if (w_mem_wr) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            r_mem_cnt <= r_mem_cnt + CW'(w_mem_wr) - CW'(w_mem_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_wr) r_mem[r_wr_ptr] <= pipe_ciphertext;
        if (w_mem_rd)      r_m_data <= r_mem[r_rd_ptr];
        else if (w_bypass) r_m_data <= pipe_ciphertext;
    end

`ifdef SIMON_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count   <= '0;
            stall_count <= '0;
        end else begin
            if (w_pop && blk_count != 32'hFFFF_FFFF) blk_count <= blk_count + 32'd1;
            if (s_valid && !s_ready && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simon_pipeline_ctrl.sv
// Bench for simon_pipeline_ctrl: behavioural Simon pipeline/key-schedule model, scoreboard queue
// filled on accept and drained by a monitor on every output handshake.
module tb_simon_pipeline_ctrl;

    localparam int PIPE_LAT  = 33;
    localparam int KEY_LAT   = 32;
    localparam int OUT_DEPTH = 36;
    localparam int NEVER     = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key_data = '0;
    logic [31:0] pipe_plaintext;
    logic [63:0] pipe_keytext;
    logic [31:0] pipe_ciphertext;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        busy;
    logic [5:0]  in_flight;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    simon_pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .pipe_plaintext(pipe_plaintext), .pipe_keytext(pipe_keytext),
        .pipe_ciphertext(pipe_ciphertext),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .in_flight(in_flight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [32];
        logic [61:0] z;
        logic [15:0] x, y, t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = key[15:0];  k[1] = key[31:16];
        k[2] = key[47:32]; k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t = {k[i-1][2:0], k[i-1][15:3]};
            t = t ^ k[i-3];
            t = t ^ {t[0], t[15:1]};
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Pipeline model: a block is encrypted correctly only if the key was stable for KEY_LAT cycles
    // before it entered and throughout its PIPE_LAT cycles inside; otherwise it comes out corrupted.
    logic [31:0] pline [PIPE_LAT];
    logic [63:0] prev_key = '0;
    int          last_change = 0;

    always @(posedge clk) begin
        pline[0] <= pipe_plaintext;
        for (int k = 1; k < PIPE_LAT; k++) pline[k] <= pline[k-1];
    end

    always @(negedge clk) begin
        if (pipe_keytext != prev_key) begin
            prev_key    = pipe_keytext;
            last_change = cyc;
        end
        if (cyc - last_change >= PIPE_LAT + KEY_LAT)
            pipe_ciphertext = simon32(pline[PIPE_LAT-1], pipe_keytext);
        else
            pipe_ciphertext = pline[PIPE_LAT-1] ^ 32'hA5A5_5A5A;
    end

    // Reference model state
    typedef struct {
        logic [31:0] d;
        int          t;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        e;
    int          acc_q[$];
    logic [63:0] ref_key = '0;
    bit          nokey = 1'b1;
    int          run_at = NEVER;
    bit          running;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_data = '0;
    int          drain_done;
    int          n_acc = 0;
    int          n_pops = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            nokey     = 1'b1;
            run_at    = NEVER;
            hold_prev = 1'b0;
        end else begin
            while (acc_q.size() > 0 && acc_q[0] < cyc - PIPE_LAT) void'(acc_q.pop_front());
            running = !nokey && (cyc >= run_at);
            check("in_flight", in_flight, acc_q.size());
            check("s_ready", s_ready, running && (exp_q.size() < OUT_DEPTH));
            check("key_ready", key_ready, nokey || running);
            check("busy", busy, !running || (acc_q.size() != 0));
            check("m_valid", m_valid, (exp_q.size() > 0) && (exp_q[0].t <= cyc - PIPE_LAT - 1));
            if (hold_prev) check("m_hold", m_data, hold_data);
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            if (m_valid && m_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL m_unexpected: got %0h expected no result (cycle %0d)", m_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.d);
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back('{d: simon32(s_data, ref_key), t: cyc});
                acc_q.push_back(cyc);
                n_acc++;
            end
            if (key_valid && key_ready) begin
                if (nokey) begin
                    nokey  = 1'b0;
                    run_at = cyc + 1 + KEY_LAT;
                end else begin
                    drain_done = (acc_q.size() > 0) ? acc_q[$] + PIPE_LAT + 1 : cyc + 1;
                    run_at     = drain_done + 1 + KEY_LAT;
                end
                ref_key = key_data;
            end
            if (exp_q.size() > OUT_DEPTH) begin
                total++;
                bad++;
                $display("FAIL overflow: got %0d outstanding expected at most %0d", exp_q.size(), OUT_DEPTH);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int h, c, n, cnt, p0, a0;

    initial begin
        repeat (3) tick;
        rst = 1'b0;

        // No key yet: nothing accepted
        s_valid = 1'b1;
        s_data  = $urandom;
        repeat (10) tick;
        check("nokey_s_ready", s_ready, 0);
        check("nokey_key_ready", key_ready, 1);
        check("nokey_busy", busy, 1);
        key_data  = 64'h1918111009080100;
        key_valid = 1'b1;
        h = cyc;
        tick;
        key_valid = 1'b0;
        s_valid   = 1'b0;
        n = 0;
        while (!s_ready && n < 200) begin tick; n++; end
        check("key_to_ready", cyc - h, 1 + KEY_LAT);

        // Known-answer block and latency
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h65656877;
        c = cyc;
        tick;
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin tick; n++; end
        check("kat_latency", cyc - c, PIPE_LAT + 1);
        check("kat_data", m_data, 32'hc69be9bb);
        tick;
        check("kat_in_flight", in_flight, 0);

        // 100 back-to-back blocks at full rate
        p0 = n_pops;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            if (!s_ready) cnt++;
            tick;
        end
        s_valid = 1'b0;
        check("stream_drops", cnt, 0);
        repeat (40) tick;
        check("stream_results", n_pops - p0, 100);

        // Backpressure: credits stop acceptance at OUT_DEPTH
        m_ready = 1'b0;
        a0 = n_acc;
        p0 = n_pops;
        for (int i = 0; i < 80; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick;
        end
        check("bp_accepts", n_acc - a0, OUT_DEPTH);
        m_ready = 1'b1;
        check("bp_first_pop_sready", s_ready, 0);
        tick;
        check("bp_resume", s_ready, 1);
        repeat (10) begin s_data = $urandom; tick; end
        s_valid = 1'b0;
        repeat (80) tick;
        check("bp_all_popped", n_pops - p0, n_acc - a0);

        // Key change with 10 blocks in flight; the 10th shares the cycle with the key handshake
        a0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            if (i == 9) begin
                key_valid = 1'b1;
                key_data  = {$urandom, $urandom};
                h = cyc;
            end
            tick;
        end
        key_valid = 1'b0;
        check("rekey_accepts", n_acc - a0, 10);
        s_data = $urandom;
        n = 0;
        while (!s_ready && n < 300) begin tick; n++; end
        check("rekey_gap", cyc - h, PIPE_LAT + 2 + KEY_LAT);
        repeat (5) begin s_data = $urandom; tick; end
        s_valid = 1'b0;
        repeat (60) tick;
        check("rekey_in_flight", in_flight, 0);

        // Reset with 20 blocks in flight
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick;
        end
        s_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        p0 = n_pops;
        check("rst_m_valid", m_valid, 0);
        check("rst_in_flight", in_flight, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 1);
        repeat (50) tick;
        check("rst_no_stale", n_pops - p0, 0);

        // Randomised traffic with occasional key changes
        key_valid = 1'b1;
        key_data  = {$urandom, $urandom};
        tick;
        key_valid = 1'b0;
        n = 0;
        while (!s_ready && n < 100) begin tick; n++; end
        check("rand_ready", s_ready, 1);
        a0 = n_acc;
        p0 = n_pops;
        for (int i = 0; i < 800; i++) begin
            s_valid   = ($urandom_range(0, 3) != 0);
            s_data    = $urandom;
            m_ready   = ($urandom_range(0, 2) != 0);
            key_valid = ($urandom_range(0, 99) == 0);
            key_data  = {$urandom, $urandom};
            tick;
        end
        s_valid   = 1'b0;
        key_valid = 1'b0;
        m_ready   = 1'b1;
        repeat (200) tick;
        check("rand_all_popped", n_pops - p0, n_acc - a0);
        check("rand_idle_m_valid", m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
